// File: rtl/time_set_controller.sv
// time_set_controller
//
// Turns two raw, active-low push-buttons ("advance minute", "advance hour")
// into single-cycle increment strobes for a time-of-day counter. Each key is
// synchronised (2 flops) and debounced. The two keys then share one
// press / auto-repeat engine: a first strobe on press, a repeat after
// REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles while the key is held.
//
// Ports:
//   CLOCK_50    in   system clock, all logic on its rising edge
//   RESET_N     in   synchronous active-low reset
//   KEY_MIN_N   in   raw minute button, 0 = pressed
//   KEY_HOUR_N  in   raw hour button, 0 = pressed
//   INC_MINUTE  out  one-cycle strobe, advance minutes by one
//   INC_HOUR    out  one-cycle strobe, advance hours by one
//   SETTING     out  high while a key owns the repeat engine
//
// Strobe semantics: INC_MINUTE / INC_HOUR are registered pulses with no
// handshake. Each high cycle means exactly one increment. They are never high
// together and never high on two consecutive cycles.
module time_set_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic KEY_MIN_N,
    input  logic KEY_HOUR_N,
    output logic INC_MINUTE,
    output logic INC_HOUR,
    output logic SETTING
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CNT_W = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] DB_LIM   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Key index 0 = minute, 1 = hour. All key levels are active-low (1 = released).
    logic [1:0] raw_n;
    assign raw_n = {KEY_HOUR_N, KEY_MIN_N};

    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            deb_q, deb_d;
    logic [1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;    // 1 = hour owns the engine
    logic [CNT_W-1:0]      rpt_cnt_q, rpt_cnt_d;
    logic                  fire;

    logic                  inc_min_q, inc_min_d;
    logic                  inc_hour_q, inc_hour_d;
    logic                  setting_q, setting_d;

    logic                  pressed_min, pressed_hour, owner_held;

    assign pressed_min  = ~deb_q[0];
    assign pressed_hour = ~deb_q[1];
    assign owner_held   = owner_q ? pressed_hour : pressed_min;

    // State register: synchroniser, debounce, FSM and output flops.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            deb_q      <= 2'b11;
            db_cnt_q   <= '0;
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            rpt_cnt_q  <= '0;
            inc_min_q  <= 1'b0;
            inc_hour_q <= 1'b0;
            setting_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            owner_q    <= owner_d;
            rpt_cnt_q  <= rpt_cnt_d;
            inc_min_q  <= inc_min_d;
            inc_hour_q <= inc_hour_d;
            setting_q  <= setting_d;
        end
    end

    // Synchroniser and debounce. The debounced level only follows the synced
    // level after it has disagreed continuously for DEBOUNCE_CYCLES cycles, so
    // any agreement in between restarts the count.
    always_comb begin
        sync1_d  = raw_n;
        sync2_d  = sync1_q;
        deb_d    = deb_q;
        db_cnt_d = db_cnt_q;
        for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] == deb_q[k]) begin
                db_cnt_d[k] = CNT_ZERO;
            end else if (db_cnt_q[k] == DB_LIM) begin
                deb_d[k]    = sync2_q[k];
                db_cnt_d[k] = CNT_ZERO;
            end else begin
                db_cnt_d[k] = db_cnt_q[k] + CNT_ONE;
            end
        end
    end

    // Next-state logic. Release of the owner is tested before the counter,
    // so a strobe due in the same cycle as the release is dropped.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rpt_cnt_d = rpt_cnt_q;
        fire      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rpt_cnt_d = CNT_ZERO;
                if (pressed_hour) begin
                    owner_d = 1'b1;
                    fire    = 1'b1;
                    state_d = ST_DELAY;
                end else if (pressed_min) begin
                    owner_d = 1'b0;
                    fire    = 1'b1;
                    state_d = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (!owner_held) begin
                    state_d   = ST_IDLE;
                    rpt_cnt_d = CNT_ZERO;
                end else if (rpt_cnt_q == RD_LAST) begin
                    fire      = 1'b1;
                    rpt_cnt_d = CNT_ZERO;
                    state_d   = ST_REPEAT;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (!owner_held) begin
                    state_d   = ST_IDLE;
                    rpt_cnt_d = CNT_ZERO;
                end else if (rpt_cnt_q == RP_LAST) begin
                    fire      = 1'b1;
                    rpt_cnt_d = CNT_ZERO;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                rpt_cnt_d = CNT_ZERO;
            end
        endcase
    end

    // Output logic, registered alongside the state transition that causes it.
    always_comb begin
        inc_min_d  = fire & ~owner_d;
        inc_hour_d = fire & owner_d;
        setting_d  = (state_d != ST_IDLE);
    end

    assign INC_MINUTE = inc_min_q;
    assign INC_HOUR   = inc_hour_q;
    assign SETTING    = setting_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Testbench for time_set_controller with short timing parameters
// (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3). Cycle n below means
// "sampled 1 ns after rising edge n", where edge 0 is the first edge that
// sees the raw key low.
module tb_time_set_controller;

    logic clk = 1'b0;
    logic rst_n;
    logic key_min_n;
    logic key_hour_n;
    logic inc_minute;
    logic inc_hour;
    logic setting;

    int total = 0;
    int bad   = 0;

    time_set_controller #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .KEY_MIN_N (key_min_n),
        .KEY_HOUR_N(key_hour_n),
        .INC_MINUTE(inc_minute),
        .INC_HOUR  (inc_hour),
        .SETTING   (setting)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard for the reset-mid-repeat sequence: expected INC_HOUR cycles.
    logic [7:0] exp_q[$];

    typedef struct {
        string name;
        int    min_start;
        int    min_len;
        int    hour_start;
        int    hour_len;
        int    run;
        int    exp_min_cnt;
        int    exp_min_first;
        int    exp_hour_cnt;
        int    exp_hour_first;
        int    exp_set_rise;
        int    exp_set_fall;
        int    exp_set_hi;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int min_cnt, hour_cnt, min_first, hour_first;
        int set_rise, set_fall, set_hi, viol;
        logic prev_strobe;

        //            name          ms ml  hs hl  run  mc mf  hc  hf  rise fall hi
        vecs[0] = '{"tap_min",     0, 8,  0, 0,  30,  1, 7,  0, -1,  7, 15,  8};
        vecs[1] = '{"tap_hour",    0, 0,  0, 8,  30,  0, -1, 1,  7,  7, 15,  8};
        vecs[2] = '{"tap_min_late", 5, 8, 0, 0,  35,  1, 12, 0, -1, 12, 20,  8};
        vecs[3] = '{"hold_hour",   0, 0,  0, 40, 60,  0, -1, 11, 7,  7, 47, 40};
        vecs[4] = '{"hold_min20",  0, 20, 0, 0,  45,  5, 7,  0, -1,  7, 27, 20};
        vecs[5] = '{"both_keys",   0, 40, 0, 20, 60,  4, 28, 5,  7,  7, 27, 39};

        // Reset with both keys released
        rst_n      = 1'b0;
        key_min_n  = 1'b1;
        key_hour_n = 1'b1;
        repeat (3) step();
        check("reset_inc_minute", int'(inc_minute), 0);
        check("reset_inc_hour",   int'(inc_hour),   0);
        check("reset_setting",    int'(setting),    0);

        // Minute key held through reset release: a fresh, fully debounced press
        key_min_n = 1'b0;
        step();
        rst_n     = 1'b1;
        min_first = -1;
        min_cnt   = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            key_min_n = (cyc < 12) ? 1'b0 : 1'b1;
            step();
            if (inc_minute) begin
                if (min_first < 0) min_first = cyc;
                min_cnt++;
            end
        end
        check("held_thru_reset_first", min_first, 7);
        check("held_thru_reset_count", min_cnt, 2);

        // Table-driven scenarios
        for (int v = 0; v < 6; v++) begin
            min_cnt = 0; hour_cnt = 0; min_first = -1; hour_first = -1;
            set_rise = -1; set_fall = -1; set_hi = 0; viol = 0;
            prev_strobe = 1'b0;
            for (int cyc = 0; cyc < vecs[v].run; cyc++) begin
                key_min_n  = (cyc >= vecs[v].min_start && cyc < vecs[v].min_start + vecs[v].min_len) ? 1'b0 : 1'b1;
                key_hour_n = (cyc >= vecs[v].hour_start && cyc < vecs[v].hour_start + vecs[v].hour_len) ? 1'b0 : 1'b1;
                step();
                if (inc_minute) begin
                    if (min_first < 0) min_first = cyc;
                    min_cnt++;
                end
                if (inc_hour) begin
                    if (hour_first < 0) hour_first = cyc;
                    hour_cnt++;
                end
                if (inc_minute && inc_hour) viol++;
                if (prev_strobe && (inc_minute || inc_hour)) viol++;
                prev_strobe = inc_minute | inc_hour;
                if (setting) begin
                    set_hi++;
                    if (set_rise < 0) set_rise = cyc;
                end else if (set_rise >= 0 && set_fall < 0) begin
                    set_fall = cyc;
                end
            end
            check({vecs[v].name, "_min_cnt"},    min_cnt,    vecs[v].exp_min_cnt);
            check({vecs[v].name, "_min_first"},  min_first,  vecs[v].exp_min_first);
            check({vecs[v].name, "_hour_cnt"},   hour_cnt,   vecs[v].exp_hour_cnt);
            check({vecs[v].name, "_hour_first"}, hour_first, vecs[v].exp_hour_first);
            check({vecs[v].name, "_set_rise"},   set_rise,   vecs[v].exp_set_rise);
            check({vecs[v].name, "_set_fall"},   set_fall,   vecs[v].exp_set_fall);
            check({vecs[v].name, "_set_hi"},     set_hi,     vecs[v].exp_set_hi);
            check({vecs[v].name, "_strobe_rules"}, viol, 0);
        end

        // Bounce: minute key toggling every 2 cycles for 12 cycles
        min_cnt = 0; hour_cnt = 0; set_hi = 0;
        key_hour_n = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            key_min_n = (cyc < 12) ? ((cyc % 4) >= 2) : 1'b1;
            step();
            if (inc_minute) min_cnt++;
            if (inc_hour)   hour_cnt++;
            if (setting)    set_hi++;
        end
        check("bounce_min_cnt",  min_cnt,  0);
        check("bounce_hour_cnt", hour_cnt, 0);
        check("bounce_set_hi",   set_hi,   0);

        // Reset mid-repeat: hour held cycles 0..45, reset sampled low at edge 21
        exp_q = {8'd7, 8'd17, 8'd20, 8'd29, 8'd39, 8'd42, 8'd45, 8'd48, 8'd51};
        min_cnt = 0; set_hi = 0;
        for (int cyc = 0; cyc < 65; cyc++) begin
            key_hour_n = (cyc < 46) ? 1'b0 : 1'b1;
            rst_n      = (cyc == 21) ? 1'b0 : 1'b1;
            step();
            if (cyc == 21) begin
                check("midreset_inc_hour", int'(inc_hour), 0);
                check("midreset_setting",  int'(setting),  0);
            end
            if (cyc > 21 && cyc < 29 && setting) set_hi++;
            if (inc_minute) min_cnt++;
            if (inc_hour) begin
                if (exp_q.size() == 0) begin
                    check("midreset_extra_strobe", cyc, -1);
                end else begin
                    check("midreset_strobe_cycle", cyc, int'(exp_q.pop_front()));
                end
            end
        end
        check("midreset_missing_strobes", exp_q.size(), 0);
        check("midreset_setting_gap", set_hi, 0);
        check("midreset_min_cnt", min_cnt, 0);

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
